decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter INSTR_W, 16, instruction width; legal values are at least 4+3*REG_W+1.
REQ-002 Parameter REG_W, 3, register-specifier width.
REQ-003 Parameter DATA_W, 16, sign-extended immediate width; legal values are at least IMM_W.
REQ-004 Parameter PC_W, 12, carried PC width; derived widths are IMM_W=INSTR_W-4-2*REG_W, FUNCT_W=INSTR_W-4-3*REG_W and JT_W=INSTR_W-4.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port flush, input, 1, synchronous discard of all buffered entries.
REQ-008 Port in_valid, input, 1, upstream instruction valid.
REQ-009 Port in_ready, output, 1, stage can accept an instruction.
REQ-010 Port in_instr, input, INSTR_W, raw instruction word.
REQ-011 Port in_pc, input, PC_W, PC of the instruction.
REQ-012 Port out_valid, output, 1, decoded entry available.
REQ-013 Port out_ready, input, 1, downstream accepts the entry.
REQ-014 Port out_opcode, output, 4, instr[INSTR_W-1 -: 4].
REQ-015 Port out_rs / out_rt / out_rd, output, REG_W each, the next three REG_W fields below the opcode, in that order.
REQ-016 Port out_funct, output, FUNCT_W, instr[FUNCT_W-1:0].
REQ-017 Port out_imm, output, DATA_W, instr[IMM_W-1:0] sign-extended.
REQ-018 Port out_jump_target, output, JT_W, instr[JT_W-1:0] unmodified.
REQ-019 Port out_pc, output, PC_W, PC carried with the entry.
REQ-020 Port out_type, output, 2, instruction class: 00 R, 01 I, 10 J, 11 illegal.
REQ-021 Port out_illegal, output, 1, illegal-opcode flag.

Function
REQ-022 Classification: opcode 0 SHALL be R; opcodes 1-11 SHALL be I; opcodes 12-13 SHALL be J; opcodes 14-15 SHALL follow REQ-034/035.
REQ-023 Decoding SHALL happen at push time, and every field SHALL be stored in a 2-entry FIFO together with its PC.
REQ-024 in_ready SHALL equal (count<2) and SHALL NOT depend combinationally on out_ready.
REQ-025 A push SHALL occur when in_valid&&in_ready; an entry pushed in cycle N SHALL present out_valid=1 in cycle N+1 (latency 1).
REQ-026 A pop SHALL occur when out_valid&&out_ready, and entries SHALL leave in push order.
REQ-027 While out_valid&&!out_ready, every out_* field SHALL hold stable.
REQ-028 Push and pop in the same cycle at count=1 SHALL leave count=1 with no bubble; at count=2 a push is impossible because in_ready=0.
REQ-029 Read and write pointers SHALL each be 1 bit and SHALL wrap modulo 2.
REQ-030 When out_valid=0, every out_* data and flag output SHALL be 0.
REQ-031 On flush=1, count SHALL become 0 next cycle, a push offered in the flush cycle SHALL be dropped, and flush SHALL take priority over push and pop.

Reset
REQ-032 While rst_n=0, count and both pointers SHALL be 0, out_valid and all out_* outputs SHALL be 0, in_ready SHALL be 1, and no handshake SHALL take effect.
REQ-033 A reset asserted mid-operation SHALL discard all entries immediately (asynchronously), and the first push after release SHALL appear one cycle later.

Configuration
REQ-034 With DECODE_ILLEGAL_EN defined, opcodes 14-15 SHALL decode as out_type=11 and out_illegal=1.
REQ-035 Without DECODE_ILLEGAL_EN, opcodes 14-15 SHALL decode as J (out_type=10), and out_illegal SHALL be constant 0.

Verification (default parameters)
REQ-036 Push 16'h0298 with pc 12'h010 -> next cycle: out_valid=1, opcode=0, rs=1, rt=2, rd=3, funct=0, type=00, pc=12'h010.
REQ-037 Push 16'h1685, then push 16'h16BC -> first entry: opcode=1, rs=3, rt=2, imm=16'h0005, type=01; second entry: imm=16'hFFFC.
REQ-038 Push 16'hC100 -> type=10, jump_target=12'h100; push 16'hE000 -> type=11, illegal=1 with DECODE_ILLEGAL_EN defined, or type=10, illegal=0 without it.
REQ-039 Hold out_ready=0 and offer 3 instructions -> in_ready=0 after 2 pushes, third instruction held upstream; raise out_ready -> all 3 emerge in order, one per cycle, no loss.
REQ-040 Fill to count=2, then pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered beat never appears at the output.
REQ-041 Assert rst_n=0 mid-stream with count=1 -> out_valid falls immediately without a clock edge; after release, the first push appears one cycle later.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: fields are decoded on entry and buffered in a 2-entry FIFO with their PC.
// Optional macro DECODE_ILLEGAL_EN: opcodes 14-15 are flagged illegal (type 11) instead of decoding as J.
module decode_stage #(
    parameter int INSTR_W = 16,
    parameter int REG_W   = 3,
    parameter int DATA_W  = 16,
    parameter int PC_W    = 12,
    localparam int IMM_W   = INSTR_W - 4 - 2 * REG_W,
    localparam int FUNCT_W = INSTR_W - 4 - 3 * REG_W,
    localparam int JT_W    = INSTR_W - 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
    output logic [FUNCT_W-1:0] out_funct,
    output logic [DATA_W-1:0]  out_imm,
    output logic [JT_W-1:0]    out_jump_target,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         out_type,
    output logic               out_illegal
);

    typedef struct packed {
        logic [3:0]         opcode;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [FUNCT_W-1:0] funct;
        logic [DATA_W-1:0]  imm;
        logic [JT_W-1:0]    jt;
        logic [PC_W-1:0]    pc;
        logic [1:0]         kind;
        logic               illegal;
    } entry_t;

    entry_t     mem [2];
    entry_t     dec;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    // flush wins over both handshakes, so neither pointer nor storage moves in a flush cycle
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        dec         = '0;
        dec.opcode  = in_instr[INSTR_W-1 -: 4];
        dec.rs      = in_instr[INSTR_W-5 -: REG_W];
        dec.rt      = in_instr[INSTR_W-5-REG_W -: REG_W];
        dec.rd      = in_instr[INSTR_W-5-2*REG_W -: REG_W];
        dec.funct   = in_instr[FUNCT_W-1:0];
        dec.imm     = DATA_W'($signed(in_instr[IMM_W-1:0]));
        dec.jt      = in_instr[JT_W-1:0];
        dec.pc      = in_pc;
        dec.illegal = 1'b0;
        if (dec.opcode == 4'd0) begin
            dec.kind = 2'b00;
        end else if (dec.opcode <= 4'd11) begin
            dec.kind = 2'b01;
        end else if (dec.opcode <= 4'd13) begin
            dec.kind = 2'b10;
        end else begin
`ifdef DECODE_ILLEGAL_EN
            dec.kind    = 2'b11;
            dec.illegal = 1'b1;
`else
            dec.kind    = 2'b10;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: it is only visible through the out_valid mask below.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_opcode      = head.opcode;
    assign out_rs          = head.rs;
    assign out_rt          = head.rt;
    assign out_rd          = head.rd;
    assign out_funct       = head.funct;
    assign out_imm         = head.imm;
    assign out_jump_target = head.jt;
    assign out_pc          = head.pc;
    assign out_type        = head.kind;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal     = head.illegal;
`else
    assign out_illegal     = 1'b0;
`endif

endmodule
